// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus as seen by the UART transmitter; the core side is master,
// the responder side is slave.
interface mmio_uart_tx_if;
    logic        ram_write;
    logic [2:0]  write_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        sel;

    modport master (
        output ram_write, write_type, mem_addr, mem_write_data,
        input  mem_read_data, sel
    );

    modport slave (
        input  ram_write, write_type, mem_addr, mem_write_data,
        output mem_read_data, sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a 16-byte register window, a TX FIFO and an
// 8N1 serialiser. Define MMIO_UART_TX_PARITY_EN for 8E1 frames with even parity.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PARITY_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [3:0]       count4;
    logic             overflow;
    logic [15:0]      divisor;
    logic [15:0]      div_eff_m1;

    state_t           state;
    logic [15:0]      timer;
    logic [15:0]      bit_len_m1;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
`ifdef MMIO_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic             wr_en;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic             empty;
    logic             idle_next;
    logic [1:0]       offset;
    logic [31:0]      reg_word;
    logic [31:0]      lane_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             unused_bits;

    assign offset      = bus.mem_addr[3:2];
    assign bus.sel     = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = bus.ram_write && bus.sel;
    assign push_req    = wr_en && (offset == 2'd0);
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign push_ok     = push_req && !full;
    assign pop         = (state == IDLE) && !empty;
    assign count4      = 4'(count);
    assign div_eff_m1  = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
    assign idle_next   = ((state == IDLE) && !pop) || ((state == STOP) && (timer == 16'd0));
    assign unused_bits = ^bus.mem_write_data[31:16];

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        reg_word = 32'h0;
        case (offset)
            2'd1:    reg_word = {20'h0, count4, 3'b000, PARITY_EN, overflow, empty, full, (state != IDLE)};
            2'd2:    reg_word = {16'h0, divisor};
            default: reg_word = 32'h0;
        endcase
    end

    // Loads pick their lane from the low address bits; words ignore them.
    always_comb begin
        byte_sel  = 8'(reg_word >> {bus.mem_addr[1:0], 3'b000});
        half_sel  = bus.mem_addr[1] ? reg_word[31:16] : reg_word[15:0];
        lane_word = reg_word;
        case (bus.write_type)
            3'b000:  lane_word = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  lane_word = {{16{half_sel[15]}}, half_sel};
            3'b100:  lane_word = {24'h0, byte_sel};
            3'b101:  lane_word = {16'h0, half_sel};
            default: lane_word = reg_word;
        endcase
        bus.mem_read_data = bus.sel ? lane_word : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.mem_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            divisor  <= DIV_RESET;
        end else begin
            count <= count_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A push into a full FIFO is lost even if a pop frees a slot this cycle.
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (wr_en && (offset == 2'd1) && bus.mem_write_data[3]) begin
                overflow <= 1'b0;
            end
            if (wr_en && (offset == 2'd2)) begin
                case (bus.write_type[1:0])
                    2'b00: begin
                        if (bus.mem_addr[1:0] == 2'd0) begin
                            divisor[7:0] <= bus.mem_write_data[7:0];
                        end else if (bus.mem_addr[1:0] == 2'd1) begin
                            divisor[15:8] <= bus.mem_write_data[7:0];
                        end
                    end
                    2'b01: begin
                        if (!bus.mem_addr[1]) begin
                            divisor <= bus.mem_write_data[15:0];
                        end
                    end
                    default: divisor <= bus.mem_write_data[15:0];
                endcase
            end
        end
    end

    // The bit length is latched at frame start so divisor writes only affect later frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            irq        <= 1'b1;
            timer      <= 16'd0;
            bit_len_m1 <= 16'd0;
            shreg      <= 8'h00;
            bit_idx    <= 3'd0;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            irq <= idle_next && (count_next == '0);
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shreg      <= fifo_mem[rd_ptr];
`ifdef MMIO_UART_TX_PARITY_EN
                        parity_bit <= ^fifo_mem[rd_ptr];
`endif
                        bit_len_m1 <= div_eff_m1;
                        timer      <= div_eff_m1;
                        tx         <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (timer == 16'd0) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= 3'd0;
                        timer   <= bit_len_m1;
                        state   <= DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer == 16'd0) begin
                        timer <= bit_len_m1;
                        if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                PARITY: begin
                    if (timer == 16'd0) begin
                        tx    <= 1'b1;
                        timer <= bit_len_m1;
                        state <= STOP;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (timer == 16'd0) begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register accesses are checked inline, serial
// frames are decoded by a monitor and compared against a queue of expected bytes.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [2:0]  F_B  = 3'b000;
    localparam logic [2:0]  F_H  = 3'b001;
    localparam logic [2:0]  F_W  = 3'b010;
    localparam logic [2:0]  F_BU = 3'b100;
    localparam logic [2:0]  F_HU = 3'b101;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
    localparam logic [31:0] P4         = 32'h0000_0010;
`else
    localparam int          FRAME_BITS = 10;
    localparam logic [31:0] P4         = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic irq;

    int   vectors     = 0;
    int   miscompares = 0;
    int   bit_cycles  = 868;
    bit   mon_busy    = 1'b0;
    logic [7:0] exp_q[$];

    logic [31:0] rdata;
    logic        rsel;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(8),
        .DIV_RESET (16'd868)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx (tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        bus.ram_write      = 1'b1;
        bus.write_type     = f3;
        bus.mem_addr       = addr;
        bus.mem_write_data = data;
        @(posedge clk);
        #1;
        bus.ram_write      = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] data, output logic s);
        bus.ram_write  = 1'b0;
        bus.write_type = f3;
        bus.mem_addr   = addr;
        @(negedge clk);
        data = bus.mem_read_data;
        s    = bus.sel;
    endtask

    task automatic waitDrain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && !mon_busy) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || mon_busy) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: %0d bytes still queued, monitor busy %0d", exp_q.size(), mon_busy);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: checks every cycle of every bit slot, so frame timing is verified too.
    initial begin : monitor
        logic        prev;
        logic [7:0]  exp_byte;
        logic [7:0]  got;
        logic [10:0] bits;
        int          d;
        int          errs;
        bit          aborted;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_frame: start bit seen with no byte expected");
                    exp_byte = 8'h00;
                end else begin
                    exp_byte = exp_q.pop_front();
                end
`ifdef MMIO_UART_TX_PARITY_EN
                bits = {1'b1, ^exp_byte, exp_byte, 1'b0};
`else
                bits = {1'b0, 1'b1, exp_byte, 1'b0};
`endif
                d       = bit_cycles;
                errs    = 0;
                got     = 8'h00;
                aborted = 1'b0;
                for (int s = 0; s < FRAME_BITS && !aborted; s++) begin
                    for (int k = 0; k < d; k++) begin
                        if (!(s == 0 && k == 0)) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== bits[s]) errs++;
                        if (k == d / 2 && s >= 1 && s <= 8) got[s-1] = tx;
                    end
                end
                if (!aborted) begin
                    checkOutput("frame_byte", {24'h0, got}, {24'h0, exp_byte});
                    checkOutput("frame_shape_errs", errs, 0);
                end
                prev     = aborted ? 1'b1 : tx;
                mon_busy = 1'b0;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] burst [10];
        burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h7E, 8'h99};

        bus.ram_write      = 1'b0;
        bus.write_type     = F_W;
        bus.mem_addr       = 32'h0;
        bus.mem_write_data = 32'h0;
        rst                = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_tx", {31'h0, tx}, 32'h1);
        checkOutput("reset_irq", {31'h0, irq}, 32'h1);
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("reset_status", rdata, 32'h4 | P4);
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("reset_divisor", rdata, 32'h0000_0364);
        checkOutput("sel_in_window", {31'h0, rsel}, 32'h1);
        readReg(F_W, BASE + 0, rdata, rsel);
        checkOutput("txdata_reads_zero", rdata, 32'h0);
        readReg(F_W, BASE + 12, rdata, rsel);
        checkOutput("reserved_reads_zero", rdata, 32'h0);

        // Single 0x55 frame at 4 clocks per bit.
        applyStimulus(F_W, BASE + 8, 32'h4);
        bit_cycles = 4;
        exp_q.push_back(8'h55);
        applyStimulus(F_W, BASE + 0, 32'h55);
        repeat (3) @(posedge clk);
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_busy", rdata, 32'h5 | P4);
        checkOutput("irq_during_frame", {31'h0, irq}, 32'h0);
        waitDrain(200);
        repeat (2) @(negedge clk);
        checkOutput("irq_after_frame", {31'h0, irq}, 32'h1);
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_idle", rdata, 32'h4 | P4);

        // Burst: nine bytes fit because the first pops; the tenth overflows.
        applyStimulus(F_W, BASE + 8, 32'h2);
        bit_cycles = 2;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(burst[i]);
            applyStimulus(F_W, BASE + 0, {24'h0, burst[i]});
        end
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_full_overflow", rdata, 32'h0000_080B | P4);
        applyStimulus(F_W, BASE + 4, 32'h8);
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_overflow_cleared", rdata, 32'h0000_0803 | P4);
        waitDrain(400);
        repeat (2) @(negedge clk);
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_after_burst", rdata, 32'h4 | P4);

        // Divisor of zero behaves as one clock per bit.
        applyStimulus(F_W, BASE + 8, 32'h0);
        bit_cycles = 1;
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("divisor_zero_readback", rdata, 32'h0);
        exp_q.push_back(8'hC3);
        applyStimulus(F_W, BASE + 0, 32'hC3);
        waitDrain(50);

        // Lane and sign handling on DIVISOR.
        pulseReset();
        applyStimulus(F_B, BASE + 9, 32'hAB);
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("sb_upper_lane", rdata, 32'h0000_AB64);
        readReg(F_H, BASE + 8, rdata, rsel);
        checkOutput("lh_sign_ext", rdata, 32'hFFFF_AB64);
        readReg(F_BU, BASE + 9, rdata, rsel);
        checkOutput("lbu_lane1", rdata, 32'h0000_00AB);
        readReg(F_HU, BASE + 10, rdata, rsel);
        checkOutput("lhu_upper_half", rdata, 32'h0);
        applyStimulus(F_H, BASE + 10, 32'h1234);
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("sh_upper_ignored", rdata, 32'h0000_AB64);
        applyStimulus(F_H, BASE + 8, 32'h00F0);
        readReg(F_B, BASE + 8, rdata, rsel);
        checkOutput("lb_sign_ext", rdata, 32'hFFFF_FFF0);
        readReg(F_BU, BASE + 8, rdata, rsel);
        checkOutput("lbu_zero_ext", rdata, 32'h0000_00F0);
        applyStimulus(F_W, 32'h2000_0008, 32'h7);
        readReg(F_W, 32'h2000_0008, rdata, rsel);
        checkOutput("outside_read_zero", rdata, 32'h0);
        checkOutput("outside_sel", {31'h0, rsel}, 32'h0);
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("outside_write_no_effect", rdata, 32'h0000_00F0);

        // Reset during data bit 3 of 0x52 (bit 3 is 0), with a second byte queued.
        applyStimulus(F_W, BASE + 8, 32'h4);
        bit_cycles = 4;
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h3C);
        applyStimulus(F_W, BASE + 0, 32'h52);
        applyStimulus(F_W, BASE + 0, 32'h3C);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("tx_data_bit3", {31'h0, tx}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("tx_after_reset", {31'h0, tx}, 32'h1);
        rst = 1'b0;
        exp_q.delete();
        readReg(F_W, BASE + 4, rdata, rsel);
        checkOutput("status_after_reset", rdata, 32'h4 | P4);
        readReg(F_W, BASE + 8, rdata, rsel);
        checkOutput("divisor_after_reset", rdata, 32'h0000_0364);
        checkOutput("irq_after_reset", {31'h0, irq}, 32'h1);

        // Recovery frames, including 0x07 which has odd bit count (parity 1).
        applyStimulus(F_W, BASE + 8, 32'h3);
        bit_cycles = 3;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h96);
        applyStimulus(F_W, BASE + 0, 32'h07);
        applyStimulus(F_W, BASE + 0, 32'h96);
        waitDrain(200);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
